multicycle_control_fsm: RTL and testbench

Sequential successor to the single-cycle RV32I control decoder. It drives a multi-cycle datapath with a shared instruction/data memory, sequencing FETCH/DECODE/EXECUTE/MEM/WRITEBACK per instruction. It adds three things the combinational decoder lacks: a memory request/ready handshake with a wait-state timeout, optional LUI/AUIPC support, and a sticky trap on illegal opcode or timeout. It sits between the instruction register/ALU flags and the datapath mux/enable controls.

---
 rtl/multicycle_control_fsm.sv | 221 ++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with a
// memory request/ready handshake, wait-state timeout and a sticky trap.
module multicycle_control_fsm #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit EN_UPPER       = 1'b1,
    parameter bit EN_LOADSTORE   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_R  = 4'd2,
        S_EXEC_I  = 4'd3,
        S_MEMADDR = 4'd4,
        S_MEMRD   = 4'd5,
        S_MEMWB   = 4'd6,
        S_MEMWR   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_JAL     = 4'd10,
        S_JALR    = 4'd11,
        S_UPPER   = 4'd12,
        S_TRAP    = 4'd15
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [7:0] TMO_LAST      = 8'(TIMEOUT_CYCLES - 1);

    state_t     state, state_nx;
    logic [7:0] wait_cnt;
    logic [1:0] cause_q, cause_nx;
    // Remembers the decoded sub-kind: store (in MEMADDR) or LUI (in UPPER).
    logic       sub_q, sub_nx;
    logic       req_state, timed_out;

    // Handshake: mem_req rises on entering a request state and stays high until
    // the cycle mem_ready is seen; only reset or a timeout trap may drop it early.
    assign req_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timed_out = req_state && !mem_ready && (wait_cnt == TMO_LAST);

    always_comb begin
        state_nx = state;
        cause_nx = cause_q;
        sub_nx   = sub_q;
        case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    state_nx = S_DECODE;
                end else if (timed_out) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                state_nx = S_TRAP;
                cause_nx = CAUSE_ILLEGAL;
                case (opcode)
                    OP_R:      begin state_nx = S_EXEC_R; cause_nx = cause_q; end
                    OP_I:      begin state_nx = S_EXEC_I; cause_nx = cause_q; end
                    OP_BRANCH: begin state_nx = S_BRANCH; cause_nx = cause_q; end
                    OP_JAL:    begin state_nx = S_JAL;    cause_nx = cause_q; end
                    OP_JALR:   begin state_nx = S_JALR;   cause_nx = cause_q; end
                    OP_LOAD, OP_STORE: begin
                        if (EN_LOADSTORE) begin
                            state_nx = S_MEMADDR;
                            cause_nx = cause_q;
                            sub_nx   = (opcode == OP_STORE);
                        end
                    end
                    OP_LUI, OP_AUIPC: begin
                        if (EN_UPPER) begin
                            state_nx = S_UPPER;
                            cause_nx = cause_q;
                            sub_nx   = (opcode == OP_LUI);
                        end
                    end
                    default: ;
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_UPPER: state_nx = S_ALUWB;
            S_MEMADDR: state_nx = sub_q ? S_MEMWR : S_MEMRD;
            S_MEMRD, S_MEMWR: begin
                if (mem_ready) begin
                    state_nx = (state == S_MEMRD) ? S_MEMWB : S_FETCH;
                end else if (timed_out) begin
                    state_nx = S_TRAP;
                    cause_nx = CAUSE_TIMEOUT;
                end
            end
            S_ALUWB, S_MEMWB, S_BRANCH, S_JAL, S_JALR: state_nx = S_FETCH;
            S_TRAP: state_nx = S_TRAP;
            default: state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            cause_q  <= 2'b00;
            sub_q    <= 1'b0;
        end else begin
            state   <= state_nx;
            cause_q <= cause_nx;
            sub_q   <= sub_nx;
            if (state_nx != state) begin
                wait_cnt <= '0;
            end else if (req_state && !mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    // Controls decode from state; FETCH and BRANCH also fold in mem_ready/alu_zero.
    // Everything is forced low while rst is held, even though state already reads FETCH.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        result_src = 2'b00;
        trap       = 1'b0;
        trap_cause = cause_q;
        state_o    = state;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_DECODE: alu_src_b = 2'b01;
                S_EXEC_R: begin
                    alu_src_a = 2'b01;
                    alu_op    = 2'b10;
                end
                S_EXEC_I: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b10;
                end
                S_MEMADDR: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                S_MEMRD: mem_req = 1'b1;
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = 2'b01;
                end
                S_MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                end
                S_ALUWB: reg_write = 1'b1;
                S_BRANCH: begin
                    alu_src_a = 2'b01;
                    alu_op    = 2'b01;
                    pc_write  = alu_zero;
                    pc_src    = 2'b01;
                end
                S_JAL: begin
                    reg_write  = 1'b1;
                    result_src = 2'b10;
                    pc_write   = 1'b1;
                    pc_src     = 2'b01;
                end
                S_JALR: begin
                    alu_src_a  = 2'b01;
                    alu_src_b  = 2'b01;
                    reg_write  = 1'b1;
                    result_src = 2'b10;
                    pc_write   = 1'b1;
                    pc_src     = 2'b10;
                end
                S_UPPER: begin
                    alu_src_a = sub_q ? 2'b10 : 2'b00;
                    alu_src_b = 2'b01;
                end
                S_TRAP: trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: a per-instruction phase model builds the expected
// output trace cycle by cycle; two instances cover the default and reduced configurations.
module tb_multicycle_control_fsm;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       alu_zero;
    logic       mem_ready;
    logic       sel;

    logic       a_mem_req, a_mem_we, a_ir_write, a_pc_write, a_reg_write, a_trap;
    logic [1:0] a_pc_src, a_alu_src_a, a_alu_src_b, a_alu_op, a_result_src, a_trap_cause;
    logic [3:0] a_state_o;
    logic       b_mem_req, b_mem_we, b_ir_write, b_pc_write, b_reg_write, b_trap;
    logic [1:0] b_pc_src, b_alu_src_a, b_alu_src_b, b_alu_op, b_result_src, b_trap_cause;
    logic [3:0] b_state_o;

    logic [21:0] obs0, obs1, obs;

    logic        rdy_q[$];
    logic        az_q[$];
    logic [6:0]  op_q[$];
    logic [21:0] exp_q[$];
    logic        cur_az;
    logic [6:0]  cur_op;
    int          vectors;
    int          miscompares;

    logic [6:0] legal_ops [9] = '{OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR,
                                  OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC};

    always #5 clk = ~clk;

    multicycle_control_fsm dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .ir_write(a_ir_write), .pc_write(a_pc_write),
        .pc_src(a_pc_src), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op),
        .reg_write(a_reg_write), .result_src(a_result_src), .trap(a_trap),
        .trap_cause(a_trap_cause), .state_o(a_state_o)
    );

    multicycle_control_fsm #(
        .TIMEOUT_CYCLES(4), .EN_UPPER(1'b0), .EN_LOADSTORE(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .ir_write(b_ir_write), .pc_write(b_pc_write),
        .pc_src(b_pc_src), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op),
        .reg_write(b_reg_write), .result_src(b_result_src), .trap(b_trap),
        .trap_cause(b_trap_cause), .state_o(b_state_o)
    );

    assign obs0 = {a_mem_req, a_mem_we, a_ir_write, a_pc_write, a_pc_src, a_alu_src_a,
                   a_alu_src_b, a_alu_op, a_reg_write, a_result_src, a_trap, a_trap_cause,
                   a_state_o};
    assign obs1 = {b_mem_req, b_mem_we, b_ir_write, b_pc_write, b_pc_src, b_alu_src_a,
                   b_alu_src_b, b_alu_op, b_reg_write, b_result_src, b_trap, b_trap_cause,
                   b_state_o};
    assign obs = sel ? obs1 : obs0;

    // Expected output word, same field order as obs.
    function automatic logic [21:0] mk(input logic [3:0] st, input logic req, we, irw, pcw,
                                       input logic [1:0] pcs, a, b, op,
                                       input logic rw, input logic [1:0] rs,
                                       input logic tr, input logic [1:0] tc);
        return {req, we, irw, pcw, pcs, a, b, op, rw, rs, tr, tc, st};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string tag, input logic [21:0] got, input logic [21:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        rdy_q.delete();
        az_q.delete();
        op_q.delete();
        exp_q.delete();
    endtask

    task automatic push(input logic rdy, input logic [21:0] v);
        rdy_q.push_back(rdy);
        az_q.push_back(cur_az);
        op_q.push_back(cur_op);
        exp_q.push_back(v);
    endtask

    // Trap is absorbing: a few cycles with random mem_ready must all read TRAP.
    task automatic push_trap(input logic [1:0] cause);
        for (int i = 0; i < 3; i++)
            push(rnd(), mk(4'd15, N, N, N, N, 2'd0, 2'd0, 2'd0, 2'd0, N, 2'd0, Y, cause));
    endtask

    // A request phase: 'waits' cycles without mem_ready, then one with it,
    // unless the wait reaches tmo cycles first.
    task automatic mem_phase(input int tmo, input logic [3:0] st, input logic we,
                             input logic fetch, input int waits, output logic trapped);
        trapped = N;
        for (int i = 0; i < waits; i++) begin
            push(N, mk(st, Y, we, N, N, 2'd0, 2'd0, 2'd0, 2'd0, N, 2'd0, N, 2'd0));
            if (i == tmo - 1) begin
                push_trap(2'd2);
                trapped = Y;
                return;
            end
        end
        push(Y, mk(st, Y, we, fetch, fetch, 2'd0, 2'd0, 2'd0, 2'd0, N, 2'd0, N, 2'd0));
    endtask

    task automatic plan_instr(input int tmo, input logic en_up, en_ls, input logic [6:0] opc,
                              input logic az, input int wf, wm, output logic trapped);
        logic [21:0] aluwb;
        aluwb  = mk(4'd8, N, N, N, N, 2'd0, 2'd0, 2'd0, 2'd0, Y, 2'd0, N, 2'd0);
        cur_az = az;
        cur_op = 7'($urandom_range(0, 127));  // opcode is don't-care during fetch
        mem_phase(tmo, 4'd0, N, Y, wf, trapped);
        if (trapped) return;
        cur_op = opc;
        push(rnd(), mk(4'd1, N, N, N, N, 2'd0, 2'd0, 2'd1, 2'd0, N, 2'd0, N, 2'd0));
        if (opc == OP_R) begin
            push(rnd(), mk(4'd2, N, N, N, N, 2'd0, 2'd1, 2'd0, 2'd2, N, 2'd0, N, 2'd0));
            push(rnd(), aluwb);
        end else if (opc == OP_I) begin
            push(rnd(), mk(4'd3, N, N, N, N, 2'd0, 2'd1, 2'd1, 2'd2, N, 2'd0, N, 2'd0));
            push(rnd(), aluwb);
        end else if (en_ls && (opc == OP_LOAD || opc == OP_STORE)) begin
            push(rnd(), mk(4'd4, N, N, N, N, 2'd0, 2'd1, 2'd1, 2'd0, N, 2'd0, N, 2'd0));
            if (opc == OP_LOAD) begin
                mem_phase(tmo, 4'd5, N, N, wm, trapped);
                if (trapped) return;
                push(rnd(), mk(4'd6, N, N, N, N, 2'd0, 2'd0, 2'd0, 2'd0, Y, 2'd1, N, 2'd0));
            end else begin
                mem_phase(tmo, 4'd7, Y, N, wm, trapped);
            end
        end else if (opc == OP_BRANCH) begin
            push(rnd(), mk(4'd9, N, N, N, az, 2'd1, 2'd1, 2'd0, 2'd1, N, 2'd0, N, 2'd0));
        end else if (opc == OP_JAL) begin
            push(rnd(), mk(4'd10, N, N, N, Y, 2'd1, 2'd0, 2'd0, 2'd0, Y, 2'd2, N, 2'd0));
        end else if (opc == OP_JALR) begin
            push(rnd(), mk(4'd11, N, N, N, Y, 2'd2, 2'd1, 2'd1, 2'd0, Y, 2'd2, N, 2'd0));
        end else if (en_up && (opc == OP_LUI || opc == OP_AUIPC)) begin
            push(rnd(), mk(4'd12, N, N, N, N, 2'd0, (opc == OP_LUI) ? 2'd2 : 2'd0, 2'd1, 2'd0,
                           N, 2'd0, N, 2'd0));
            push(rnd(), aluwb);
        end else begin
            push_trap(2'd1);
            trapped = Y;
        end
    endtask

    // Called at a negedge; applies one planned cycle per negedge.
    task automatic run(input int n, input string tag);
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            mem_ready = rdy_q.pop_front();
            alu_zero  = az_q.pop_front();
            opcode    = op_q.pop_front();
            #1;
            check(tag, obs, exp_q.pop_front());
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        clear_q();
        mem_ready = Y;  // must not leak into ir_write/pc_write while held in reset
        alu_zero  = Y;
        rst       = Y;
        @(negedge clk);
        #1;
        check("reset", obs, 22'd0);
        @(negedge clk);
        rst       = N;
        mem_ready = N;
    endtask

    initial begin
        logic t;
        vectors     = 0;
        miscompares = 0;
        sel         = N;
        rst         = Y;
        mem_ready   = N;
        alu_zero    = N;
        opcode      = 7'd0;
        cur_az      = N;
        cur_op      = 7'd0;

        // Default configuration: directed instructions, then a random stream.
        do_reset();
        plan_instr(16, Y, Y, OP_R,      N, 0, 0, t);
        plan_instr(16, Y, Y, OP_LOAD,   N, 0, 3, t);
        plan_instr(16, Y, Y, OP_BRANCH, Y, 0, 0, t);
        plan_instr(16, Y, Y, OP_BRANCH, N, 1, 0, t);
        plan_instr(16, Y, Y, OP_STORE,  N, 2, 2, t);
        plan_instr(16, Y, Y, OP_JAL,    N, 0, 0, t);
        plan_instr(16, Y, Y, OP_JALR,   N, 0, 0, t);
        plan_instr(16, Y, Y, OP_LUI,    N, 0, 0, t);
        plan_instr(16, Y, Y, OP_AUIPC,  N, 0, 0, t);
        plan_instr(16, Y, Y, OP_I,      N, 0, 0, t);
        run(exp_q.size(), "directed");
        for (int k = 0; k < 40; k++)
            plan_instr(16, Y, Y, legal_ops[$urandom_range(0, 8)], rnd(),
                       $urandom_range(0, 3), $urandom_range(0, 3), t);
        run(exp_q.size(), "random_a");

        // Longest legal wait, then a store that times out.
        plan_instr(16, Y, Y, OP_LOAD,  N, 15, 15, t);
        plan_instr(16, Y, Y, OP_STORE, N, 0, 40, t);
        run(exp_q.size(), "timeout16");

        do_reset();
        plan_instr(16, Y, Y, 7'b1111111, N, 0, 0, t);
        run(exp_q.size(), "illegal");

        // Reset in the middle of a store handshake.
        do_reset();
        plan_instr(16, Y, Y, OP_STORE, N, 0, 10, t);
        run(5, "pre_rst");
        mem_ready = N;
        #2;
        rst = Y;
        #1;
        check("mid_rst", obs, 22'd0);
        @(negedge clk);
        rst = N;
        clear_q();
        plan_instr(16, Y, Y, OP_R, N, 0, 0, t);
        run(exp_q.size(), "post_rst");

        // Reduced configuration: timeout 4, no upper, no load/store.
        sel = Y;
        do_reset();
        plan_instr(4, N, N, OP_LUI, N, 0, 0, t);
        run(exp_q.size(), "lui_off");
        do_reset();
        plan_instr(4, N, N, OP_AUIPC, N, 0, 0, t);
        run(exp_q.size(), "auipc_off");
        do_reset();
        plan_instr(4, N, N, OP_LOAD, N, 0, 0, t);
        run(exp_q.size(), "load_off");
        do_reset();
        plan_instr(4, N, N, OP_STORE, N, 1, 0, t);
        run(exp_q.size(), "store_off");
        do_reset();
        plan_instr(4, N, N, OP_R, N, 100, 0, t);
        run(exp_q.size(), "fetch_tmo");
        do_reset();
        plan_instr(4, N, N, OP_R, N, 3, 0, t);
        for (int k = 0; k < 30; k++)
            plan_instr(4, N, N, legal_ops[$urandom_range(0, 4)], rnd(),
                       $urandom_range(0, 3), 0, t);
        run(exp_q.size(), "random_b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
